coax_tx: RTL and testbench



---
 rtl/coax_tx.sv | 176 +++++++++++++++++
 tb/tb_coax_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/coax_tx.sv
// rtl/coax_tx.sv - 3270 coax transmitter: quiesce, code violation, sync/data/parity words, ending sequence.
// Optional COAX_TX_DELAY_EN adds tx_delay, tx delayed by CLOCKS_PER_BIT/4 clocks.
module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       tx_active
`ifdef COAX_TX_DELAY_EN
  ,
  output logic       tx_delay
`endif
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(CLOCKS_PER_BIT / 2);
  localparam int CV_HIGH = (3 * CLOCKS_PER_BIT) / 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_QUIESCE = 3'd1;
  localparam logic [2:0] S_CV      = 3'd2;
  localparam logic [2:0] S_SYNC    = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_PARITY  = 3'd5;
  localparam logic [2:0] S_END0    = 3'd6;
  localparam logic [2:0] S_ENDH    = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [9:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic          ready_q, ready_d;
  logic          tx_q, tx_d;
  logic          tx_active_q, tx_active_d;
  logic          accept, load, is_cell, cell_val;
  logic [3:0]    last_bit;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    hold_d   = hold_q;
    load     = 1'b0;
    accept   = data_valid && ready_q;

    // Number of cells in each state, minus one; CV and ENDH count whole cells too.
    case (state_q)
      S_QUIESCE: last_bit = 4'd4;
      S_CV:      last_bit = 4'd2;
      S_DATA:    last_bit = 4'd9;
      S_ENDH:    last_bit = 4'd1;
      default:   last_bit = 4'd0;
    endcase

    if (state_q == S_IDLE) begin
      cyc_d = '0;
      bit_d = '0;
      if (full_q || accept) state_d = S_QUIESCE;
    end else if (cyc_q == CYC_LAST) begin
      cyc_d = '0;
      if (state_q == S_DATA) shift_d = {shift_q[8:0], 1'b0};
      if (bit_q == last_bit) begin
        bit_d = '0;
        case (state_q)
          S_QUIESCE: state_d = S_CV;
          S_CV:      begin state_d = S_SYNC; load = 1'b1; end
          S_SYNC:    state_d = S_DATA;
          S_DATA:    state_d = S_PARITY;
          S_PARITY:  begin
            if (full_q) begin
              state_d = S_SYNC;
              load    = 1'b1;
            end else begin
              state_d = S_END0;
            end
          end
          S_END0:    state_d = S_ENDH;
          default:   state_d = S_IDLE;
        endcase
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end

    // A load frees the holding register; a same-cycle accept refills it with the new word.
    if (load) begin
      shift_d = hold_q;
      par_d   = ^hold_q;
    end
    if (accept) hold_d = data;
    full_d  = (full_q && !load) || accept;
    ready_d = !full_d;

    is_cell  = 1'b1;
    cell_val = 1'b0;
    tx_d     = 1'b0;
    case (state_d)
      S_QUIESCE, S_SYNC: cell_val = 1'b1;
      S_DATA:            cell_val = shift_d[9];
      S_PARITY:          cell_val = par_d;
      S_END0:            cell_val = 1'b0;
      S_CV: begin
        is_cell = 1'b0;
        tx_d    = (int'(bit_d) * CLOCKS_PER_BIT + int'(cyc_d)) < CV_HIGH;
      end
      S_ENDH: begin
        is_cell = 1'b0;
        tx_d    = 1'b1;
      end
      default: is_cell = 1'b0;
    endcase
    if (is_cell) tx_d = (cyc_d < CYC_HALF) ? ~cell_val : cell_val;
    tx_active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      ready_q     <= 1'b1;
      tx_q        <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign ready     = ready_q;
  assign tx        = tx_q;
  assign tx_active = tx_active_q;

`ifdef COAX_TX_DELAY_EN
  localparam int DLY = CLOCKS_PER_BIT / 4;
  logic [DLY-1:0] dly_q, dly_d;

  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = tx_q;
    for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dly_q <= '0;
    else       dly_q <= dly_d;
  end

  assign tx_delay = dly_q[DLY-1];
`endif

endmodule

// File: tb/tb_coax_tx.sv
// tb/tb_coax_tx.sv - randomized and directed bench for coax_tx against a waveform-queue reference model.
module tb_coax_tx;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       data_valid;
  logic       ready, tx, tx_active;
`ifdef COAX_TX_DELAY_EN
  logic       tx_delay;
`endif

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .ready(ready), .tx(tx), .tx_active(tx_active)
`ifdef COAX_TX_DELAY_EN
    , .tx_delay(tx_delay)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the future line waveform is a queue of samples; actions fire when it drains.
  bit         wave[$];
  int         act;       // 0 idle, 1 load first word, 2 after parity, 3 finish
  bit         m_full;
  logic [9:0] m_word;
  bit         m_tx, m_act, m_ready;
  bit         m_hist[$];
  bit         m_dly;

  task automatic push_cell(input bit b);
    for (int i = 0; i < CPB; i++) wave.push_back(i < CPB/2 ? !b : b);
  endtask

  task automatic push_word(input logic [9:0] w);
    push_cell(1'b1);
    for (int i = 9; i >= 0; i--) push_cell(w[i]);
    push_cell(^w);
  endtask

  task automatic model_reset();
    wave.delete();
    act = 0; m_full = 0; m_word = '0;
    m_tx = 0; m_act = 0; m_ready = 1; m_dly = 0;
    m_hist.delete();
    for (int i = 0; i < CPB/4 - 1; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic dv, input logic [9:0] d);
    bit accept;
    accept = dv && !m_full;
    m_hist.push_back(m_tx);
    m_dly = m_hist.pop_front();
    if (act == 0) begin
      if (m_full || accept) begin
        for (int i = 0; i < 5; i++) push_cell(1'b1);
        for (int i = 0; i < 3*CPB/2; i++) wave.push_back(1'b1);
        for (int i = 0; i < 3*CPB/2; i++) wave.push_back(1'b0);
        act = 1;
      end
    end else if (wave.size() == 0) begin
      if (act == 3) begin
        act = 0;
      end else if (act == 1 || m_full) begin
        push_word(m_word);
        m_full = 0;
        act = 2;
      end else begin
        push_cell(1'b0);
        for (int i = 0; i < 2*CPB; i++) wave.push_back(1'b1);
        act = 3;
      end
    end
    if (act != 0) begin m_tx = wave.pop_front(); m_act = 1; end
    else begin m_tx = 0; m_act = 0; end
    if (accept) begin m_word = d; m_full = 1; end
    m_ready = !m_full;
  endtask

  int   cyc_idx = 0;
  int   act_cnt = 0;
  logic rec_tx[0:399];
  logic rec_act[0:399];

  task automatic drive(input logic dv, input logic [9:0] d);
    data_valid = dv;
    data       = d;
    @(posedge clk);
    model_step(dv, d);
    #1;
    check("tx", {31'd0, tx}, {31'd0, m_tx});
    check("tx_active", {31'd0, tx_active}, {31'd0, m_act});
    check("ready", {31'd0, ready}, {31'd0, m_ready});
`ifdef COAX_TX_DELAY_EN
    check("tx_delay", {31'd0, tx_delay}, {31'd0, m_dly});
`endif
    if (cyc_idx >= 0 && cyc_idx < 400) begin
      rec_tx[cyc_idx]  = tx;
      rec_act[cyc_idx] = tx_active;
    end
    if (tx_active) act_cnt++;
    cyc_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 10'($urandom));
  endtask

  task automatic start_window();
    cyc_idx = 1;
    act_cnt = 0;
  endtask

  task automatic do_reset(input string tag);
    data_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check({tag, "_tx"}, {31'd0, tx}, 32'd0);
    check({tag, "_tx_active"}, {31'd0, tx_active}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    data_valid = 1'b0;
    data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd0);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    reset = 1'b0;
    idle(5);

    // Single word 0x2A5.
    start_window();
    drive(1'b1, 10'h2A5);
    idle(210);
    check("w1_len", act_cnt, 184);
    check("w1_q_lo", {31'd0, rec_tx[1]}, 32'd0);
    check("w1_q_hi", {31'd0, rec_tx[5]}, 32'd1);
    check("w1_cv_hi0", {31'd0, rec_tx[41]}, 32'd1);
    check("w1_cv_hi1", {31'd0, rec_tx[52]}, 32'd1);
    check("w1_cv_lo0", {31'd0, rec_tx[53]}, 32'd0);
    check("w1_cv_lo1", {31'd0, rec_tx[64]}, 32'd0);
    check("w1_sync_lo", {31'd0, rec_tx[65]}, 32'd0);
    check("w1_d9_hi", {31'd0, rec_tx[77]}, 32'd1);
    check("w1_d8_lo", {31'd0, rec_tx[81]}, 32'd1);
    check("w1_par_hi", {31'd0, rec_tx[157]}, 32'd1);
    check("w1_end0", {31'd0, rec_tx[161]}, 32'd1);
    check("w1_endh", {31'd0, rec_tx[184]}, 32'd1);
    check("w1_act_end", {31'd0, rec_act[184]}, 32'd1);
    check("w1_idle_tx", {31'd0, rec_tx[185]}, 32'd0);
    check("w1_idle_act", {31'd0, rec_act[185]}, 32'd0);

    // Back-to-back 0x3FF then 0x000.
    start_window();
    drive(1'b1, 10'h3FF);
    idle(80);
    drive(1'b1, 10'h000);
    idle(250);
    check("b2b_len", act_cnt, 280);
    check("b2b_sync2", {31'd0, rec_tx[161]}, 32'd0);
    check("b2b_par1", {31'd0, rec_tx[153]}, 32'd1);
    check("b2b_par2", {31'd0, rec_tx[253]}, 32'd0);
    check("b2b_act_end", {31'd0, rec_act[281]}, 32'd0);

    // data_valid held with changing data while ready is low.
    for (int i = 0; i < 300; i++) drive(1'b1, 10'($urandom));
    idle(400);

    // Word accepted during ENDH.
    start_window();
    drive(1'b1, 10'h155);
    idle(175);
    drive(1'b1, 10'h0AB);
    idle(400);
    check("endh_gap_act", {31'd0, rec_act[185]}, 32'd0);
    check("endh_gap_tx", {31'd0, rec_tx[185]}, 32'd0);
    check("endh_restart", {31'd0, rec_act[186]}, 32'd1);

    // Reset mid-DATA, then silence.
    drive(1'b1, 10'h2C3);
    idle(90);
    do_reset("mid");
    idle(50);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) drive(1'b1, 10'($urandom));
      else drive(1'b0, 10'($urandom));
    end
    idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
